// File: rtl/fnd_scan_ctrl.sv
// Scan controller for the 4-digit FND: paged mux select, blanking gap,
// active-low commons and a blinking decimal point.
module fnd_scan_ctrl #(
  parameter int CLK_DIV      = 100_000,
  parameter int GAP_CYC      = 1_000,
  parameter int BLINK_FRAMES = 125,
  parameter int DP_SLOT      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       page_req,
  input  logic       dot_blink_en,
  input  logic [3:0] blank_mask,
  output logic [2:0] sel,
  output logic [3:0] fnd_com,
  output logic       fnd_dp,
  output logic       page_cur,
  output logic       frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SHOW_LD =
    CW'(CLK_DIV - GAP_CYC - 1);
  localparam logic [FW-1:0] FR_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    DP_POS  = 2'(DP_SLOT);

  typedef enum logic {
    GAP,
    SHOW
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    scan, scan_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic          blink, blink_n;
  logic          page_n;
  logic          wrap;
  logic [3:0]    com_n;
  logic          dp_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= GAP;
      cnt         <= GAP_LD;
      scan        <= 2'd0;
      page_cur    <= 1'b0;
      frame_cnt   <= '0;
      blink       <= 1'b0;
      sel         <= 3'b000;
      fnd_com     <= 4'b1111;
      fnd_dp      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      scan        <= scan_n;
      page_cur    <= page_n;
      frame_cnt   <= frame_cnt_n;
      blink       <= blink_n;
      sel         <= {page_n, scan_n};
      fnd_com     <= com_n;
      fnd_dp      <= dp_n;
      frame_start <= wrap;
    end
  end

  // Outputs are built from next-state values so they stay registered.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    scan_n      = scan;
    page_n      = page_cur;
    frame_cnt_n = frame_cnt;
    blink_n     = blink;
    wrap        = 1'b0;
    com_n       = 4'b1111;
    dp_n        = 1'b1;

    unique case (state)
      GAP: begin
        if (cnt == '0) begin
          state_n = SHOW;
          cnt_n   = SHOW_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      SHOW: begin
        if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = GAP_LD;
          scan_n  = scan + 2'd1;
          wrap    = (scan == 2'd3);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: ;
    endcase

    if (wrap) begin
      page_n = page_req;
      if (frame_cnt == FR_LAST) begin
        frame_cnt_n = '0;
        blink_n     = ~blink;
      end else begin
        frame_cnt_n = frame_cnt + FW'(1);
      end
    end

    if (state_n == SHOW && !blank_mask[scan_n]) begin
      com_n[scan_n] = 1'b0;
      if (scan_n == DP_POS && dot_blink_en && blink_n)
        dp_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomized bench for fnd_scan_ctrl against a cycle-count
// reference model of the scan timing.
module tb_fnd_scan_ctrl;

  localparam int CD  = 10;
  localparam int GC  = 2;
  localparam int BF  = 2;
  localparam int DPS = 2;
  localparam int FRM = 4 * CD;

  logic       clk = 1'b0;
  logic       reset;
  logic       page_req;
  logic       dot_blink_en;
  logic [3:0] blank_mask;
  logic [2:0] sel;
  logic [3:0] fnd_com;
  logic       fnd_dp;
  logic       page_cur;
  logic       frame_start;

  int vectors = 0;
  int miscompares = 0;

  int         m_p = 0;
  logic       m_pg = 1'b0;
  logic [2:0] e_sel;
  logic [3:0] e_com;
  logic       e_dp;
  logic       e_fs;
  logic [2:0] prev_sel = 3'b000;

  fnd_scan_ctrl #(
    .CLK_DIV     (CD),
    .GAP_CYC     (GC),
    .BLINK_FRAMES(BF),
    .DP_SLOT     (DPS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .page_req    (page_req),
    .dot_blink_en(dot_blink_en),
    .blank_mask  (blank_mask),
    .sel         (sel),
    .fnd_com     (fnd_com),
    .fnd_dp      (fnd_dp),
    .page_cur    (page_cur),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s p=%0d got=%h exp=%h",
               tag, m_p, got, exp);
    end
  endtask

  // Expected outputs follow from the cycle index since reset alone.
  task automatic model(input logic r, input logic pr,
                       input logic [3:0] bm,
                       input logic de);
    int scan, ph, fr;
    logic lit, bl;
    if (r) begin
      m_p  = 0;
      m_pg = 1'b0;
      e_sel = 3'b000;
      e_com = 4'hF;
      e_dp  = 1'b1;
      e_fs  = 1'b0;
    end else begin
      m_p++;
      if (m_p % FRM == 0) m_pg = pr;
      scan = (m_p / CD) % 4;
      ph   = m_p % CD;
      lit  = (ph >= GC);
      fr   = m_p / FRM;
      bl   = ((fr / BF) % 2) == 1;
      e_sel = {m_pg, 2'(scan)};
      e_com = 4'hF;
      e_dp  = 1'b1;
      if (lit && !bm[scan]) begin
        e_com[scan] = 1'b0;
        if (scan == DPS && de && bl) e_dp = 1'b0;
      end
      e_fs = (m_p % FRM == 0);
    end
  endtask

  task automatic step(input logic r, input logic pr,
                      input logic [3:0] bm,
                      input logic de);
    reset        = r;
    page_req     = pr;
    blank_mask   = bm;
    dot_blink_en = de;
    @(posedge clk);
    model(r, pr, bm, de);
    @(negedge clk);
    chk("sel", 32'(sel), 32'(e_sel));
    chk("fnd_com", 32'(fnd_com), 32'(e_com));
    chk("fnd_dp", 32'(fnd_dp), 32'(e_dp));
    chk("page_cur", 32'(page_cur), 32'(e_sel[2]));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("com_onehot", 32'($countones(~fnd_com) <= 1), 32'd1);
    if (sel !== prev_sel)
      chk("sel_gap", 32'(fnd_com), 32'hF);
    prev_sel = sel;
  endtask

  initial begin
    logic pr;
    logic hit;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b0);

    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 4'h0, 1'b0);

    // Mid-frame page request and glitches within the next frame.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      pr = (i < 10) || (i >= 20 && i < 25) || (i >= 35);
      step(1'b0, pr, 4'h0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      pr = (i >= 5 && i < 30);
      step(1'b0, pr, 4'h0, 1'b0);
    end

    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 4'b0100, 1'b0);

    step(1'b1, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 8 * FRM; i++)
      step(1'b0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 4 * FRM; i++)
      step(1'b0, 1'b0, 4'h0, 1'b0);

    // Reset during the lit part of scan 3 on page 1.
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_pg && (m_p % FRM) >= 3 * CD + GC + 1) hit = 1'b1;
      else step(1'b0, 1'b1, 4'h0, 1'b0);
    end
    chk("reach_scan3", 32'(hit), 32'd1);
    step(1'b1, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 4'h0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 15) == 0) ? ~page_req : page_req,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
           ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
